// File: rtl/cmp_share_arb.sv
// cmp_share_arb
// Round-robin arbiter that shares a single relational comparator among NREQ
// requesters. One request is granted at a time, its operands are captured,
// the compare is evaluated in a registered stage, and a 1-bit result is
// returned together with the owning requester index.
//
// Build option: define CMP_SIGNED_EN to widen opcodes to 4 bits. Bit 3 then
// selects a two's-complement compare for GT/GE/LT/LE. Without the macro,
// opcodes are 3 bits and all compares are unsigned.
//
// Handshake semantics:
//   - Request side: a requester holds req_valid[i] and its operands until it
//     sees req_ready[i]. req_ready is a one-cycle, one-hot pulse, produced
//     combinationally in IDLE. A transfer happens on the rising edge where
//     req_valid[i] and req_ready[i] are both high. Dropping req_valid before
//     a grant is allowed, and that requester is then skipped.
//   - Response side: rsp_valid stays high in RESP and every rsp_* output is
//     stable until the rising edge where rsp_valid and rsp_ready are both
//     high. After that edge rsp_valid goes low, so two results are never
//     issued back to back.
module cmp_share_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
`ifdef CMP_SIGNED_EN
  input  logic [NREQ*4-1:0]     req_op,
`else
  input  logic [NREQ*3-1:0]     req_op,
`endif
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_result,
  output logic                  rsp_err,
  output logic                  busy
);

`ifdef CMP_SIGNED_EN
  localparam int OPW = 4;
`else
  localparam int OPW = 3;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Round-robin pointer: index that has highest priority in the next scan
  logic [IDW-1:0] rr_ptr;

  // Arbitration results
  logic           any_valid;
  logic [IDW-1:0] sel;
  logic           grant;

  // Operand mux output for the selected requester
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OPW-1:0]   sel_op;

  // Captured transaction
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic [OPW-1:0]   cap_op;
  logic [IDW-1:0]   cap_id;

  // Comparator outputs
  logic cmp_res;
  logic cmp_err;

  // Round-robin pick: first valid at or above rr_ptr, otherwise first valid overall
  always_comb begin
    logic           hi_any;
    logic           lo_any;
    logic [IDW-1:0] hi_sel;
    logic [IDW-1:0] lo_sel;
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_sel = '0;
    lo_sel = '0;
    // Scan from the top down so the lowest matching index is the one kept
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_any = 1'b1;
        lo_sel = IDW'(i);
        if (IDW'(i) >= rr_ptr) begin
          hi_any = 1'b1;
          hi_sel = IDW'(i);
        end
      end
    end
    any_valid = lo_any;
    sel       = hi_any ? hi_sel : lo_sel;
    grant     = (state == IDLE) && lo_any;
  end

  // Select the operand slices that belong to the chosen requester
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == IDW'(i)) begin
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
        sel_op = req_op[i*OPW +: OPW];
      end
    end
  end

  // Shared comparator working on the captured operands
  always_comb begin
    logic eq;
    logic lt;
    eq = (cap_a == cap_b);
`ifdef CMP_SIGNED_EN
    // Bit 3 switches the ordering compares to two's complement
    lt = cap_op[3] ? ($signed(cap_a) < $signed(cap_b)) : (cap_a < cap_b);
`else
    lt = (cap_a < cap_b);
`endif
    cmp_res = 1'b0;
    cmp_err = 1'b0;
    case (cap_op[2:0])
      3'd0:    cmp_res = eq;
      3'd1:    cmp_res = ~eq;
      3'd2:    cmp_res = ~lt & ~eq;
      3'd3:    cmp_res = ~lt;
      3'd4:    cmp_res = lt;
      3'd5:    cmp_res = lt | eq;
      default: cmp_err = 1'b1;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: one-hot grant in IDLE, result valid in RESP
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant && (sel == IDW'(i));
    end
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // Capture on grant and advance the round-robin pointer past the winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      cap_a  <= '0;
      cap_b  <= '0;
      cap_op <= '0;
      cap_id <= '0;
    end else if (grant) begin
      cap_a  <= sel_a;
      cap_b  <= sel_b;
      cap_op <= sel_op;
      cap_id <= sel;
      rr_ptr <= (sel == IDW'(NREQ - 1)) ? '0 : sel + 1'b1;
    end
  end

  // Register the comparison result in EXEC. It holds through RESP and afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id     <= '0;
      rsp_result <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id     <= cap_id;
      rsp_result <= cmp_res;
      rsp_err    <= cmp_err;
    end
  end

endmodule

// File: tb/tb_cmp_share_arb.sv
// tb_cmp_share_arb: self-checking bench for cmp_share_arb.
// A transaction-level model (round-robin scan using modulo arithmetic,
// comparisons done on plain integers) is checked against the DUT on every
// negative clock edge. Directed sequences add hand-computed literal checks.
module tb_cmp_share_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;
`ifdef CMP_SIGNED_EN
  localparam int OPW = 4;
`else
  localparam int OPW = 3;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*OPW-1:0]   req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_result;
  logic                  rsp_err;
  logic                  busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cmp_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  // ---------------- check bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Returns {result, err} computed with plain integer comparisons.
  function automatic logic [1:0] model_cmp(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [OPW-1:0] op);
    longint va;
    longint vb;
    va = longint'(a);
    vb = longint'(b);
`ifdef CMP_SIGNED_EN
    if (op[3]) begin
      if (a[WIDTH-1]) va = va - (longint'(1) << WIDTH);
      if (b[WIDTH-1]) vb = vb - (longint'(1) << WIDTH);
    end
`endif
    case (op[2:0])
      3'd0:    return {(va == vb), 1'b0};
      3'd1:    return {(va != vb), 1'b0};
      3'd2:    return {(va >  vb), 1'b0};
      3'd3:    return {(va >= vb), 1'b0};
      3'd4:    return {(va <  vb), 1'b0};
      3'd5:    return {(va <= vb), 1'b0};
      default: return 2'b01;
    endcase
  endfunction

  // Scoreboard: expected responses {id, result, err} in grant order
  logic [IDW+1:0] exp_q[$];
  bit             m_busy;   // a transaction is outstanding
  int             m_age;    // cycles since its grant
  int             m_rr;     // next index with top priority
  int             m_sel;
  int             m_idx;
  bit             m_found;
  logic [NREQ-1:0] m_ready;
  logic [IDW+1:0]  m_head;

  // Compare process: the model advances once per cycle, and the DUT is sampled on negedge
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready",  32'(req_ready),  32'(0));
      chk("rst_rsp_valid",  32'(rsp_valid),  32'(0));
      chk("rst_rsp_id",     32'(rsp_id),     32'(0));
      chk("rst_rsp_result", 32'(rsp_result), 32'(0));
      chk("rst_rsp_err",    32'(rsp_err),    32'(0));
      chk("rst_busy",       32'(busy),       32'(0));
      m_busy = 1'b0;
      m_age  = 0;
      m_rr   = 0;
      exp_q.delete();
    end else if (!m_busy) begin
      m_found = 1'b0;
      m_sel   = 0;
      for (int k = 0; k < NREQ; k++) begin
        m_idx = (m_rr + k) % NREQ;
        if (!m_found && req_valid[m_idx]) begin
          m_found = 1'b1;
          m_sel   = m_idx;
        end
      end
      m_ready = '0;
      if (m_found) m_ready[m_sel] = 1'b1;
      chk("mdl_req_ready", 32'(req_ready), 32'(m_ready));
      chk("mdl_idle_busy", 32'(busy), 32'(0));
      chk("mdl_idle_rsp_valid", 32'(rsp_valid), 32'(0));
      if (m_found) begin
        exp_q.push_back({IDW'(m_sel),
                         model_cmp(req_a[m_sel*WIDTH +: WIDTH],
                                   req_b[m_sel*WIDTH +: WIDTH],
                                   req_op[m_sel*OPW +: OPW])});
        m_busy = 1'b1;
        m_age  = 0;
        m_rr   = (m_sel + 1) % NREQ;
      end
    end else begin
      m_age++;
      chk("mdl_busy_req_ready", 32'(req_ready), 32'(0));
      chk("mdl_busy", 32'(busy), 32'(1));
      chk("mdl_rsp_valid", 32'(rsp_valid), 32'(m_age >= 2));
      if (m_age >= 2) begin
        m_head = exp_q[0];
        chk("mdl_rsp_id",     32'(rsp_id),     32'(m_head[IDW+1:2]));
        chk("mdl_rsp_result", 32'(rsp_result), 32'(m_head[1]));
        chk("mdl_rsp_err",    32'(rsp_err),    32'(m_head[0]));
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          m_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic new_ops(input int i);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    a = WIDTH'($urandom);
    case ($urandom_range(0, 3))
      0:       b = a;
      1:       b = a + 1'b1;
      default: b = WIDTH'($urandom);
    endcase
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_op[i*OPW +: OPW]    = OPW'($urandom_range(0, (1 << OPW) - 1));
  endtask

  // Issue one request from a single requester and collect its response
  task automatic do_one(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [OPW-1:0] op, output logic res, output logic err,
                        output int id, output int lat);
    int n;
    @(posedge clk); #1;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
    req_op[idx*OPW +: OPW]    = op;
    n = 0;
    @(negedge clk);
    while (req_ready === '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant_wait", 32'(n < 20), 32'(1));
    chk("grant_onehot", 32'(req_ready), 32'(1) << idx);
    @(posedge clk); #1;
    req_valid = '0;
    lat = 1;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = rsp_result;
    err = rsp_err;
    id  = int'(rsp_id);
    @(posedge clk); #1;
  endtask

  task automatic run_random(input int cycles);
    logic [NREQ-1:0] g;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      g = req_ready;
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          new_ops(i);
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          new_ops(i);
        end
      end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  logic      r;
  logic      e;
  int        id;
  int        lat;
  int        n;
  int        got;
  int        order[5];
  int        exp_order[5] = '{0, 1, 2, 3, 0};
  logic [5:0] exp_u = 6'b001110;   // bit k: result for opcode k, 0x80 vs 0x7F unsigned
`ifdef CMP_SIGNED_EN
  logic [5:0] exp_s = 6'b110000;   // bit k: result for signed opcode k (k = 2..5)
`endif

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset_busy",      32'(busy),      32'(0));
    chk("reset_rsp_id",    32'(rsp_id),    32'(0));
    rst = 1'b0;

    // Single request with a literal expected latency and result
    do_one(0, 8'h05, 8'h05, OPW'(0), r, e, id, lat);
    chk("single_lat", 32'(lat), 32'(2));
    chk("single_id",  32'(id),  32'(0));
    chk("single_res", 32'(r),   32'(1));
    chk("single_err", 32'(e),   32'(0));

    // All six opcodes on 0x80 vs 0x7F
    for (int k = 0; k < 6; k++) begin
      do_one(1, 8'h80, 8'h7F, OPW'(k), r, e, id, lat);
      chk($sformatf("op%0d_unsigned", k), 32'(r), 32'(exp_u[k]));
      chk($sformatf("op%0d_err", k), 32'(e), 32'(0));
    end
`ifdef CMP_SIGNED_EN
    for (int k = 2; k < 6; k++) begin
      do_one(1, 8'h80, 8'h7F, OPW'(8 + k), r, e, id, lat);
      chk($sformatf("op%0d_signed", k), 32'(r), 32'(exp_s[k]));
    end
`endif

    // Illegal opcodes
    do_one(2, 8'h11, 8'h22, OPW'(6), r, e, id, lat);
    chk("illegal6_id",  32'(id), 32'(2));
    chk("illegal6_res", 32'(r),  32'(0));
    chk("illegal6_err", 32'(e),  32'(1));
    do_one(3, 8'h00, 8'h00, OPW'(7), r, e, id, lat);
    chk("illegal7_res", 32'(r),  32'(0));
    chk("illegal7_err", 32'(e),  32'(1));

    // Backpressure: hold rsp_ready low while another requester waits
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_a[1*WIDTH +: WIDTH] = 8'h03;
    req_b[1*WIDTH +: WIDTH] = 8'h09;
    req_op[1*OPW +: OPW]    = OPW'(4);
    n = 0;
    @(negedge clk);
    while (req_ready === '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_grant", 32'(req_ready), 32'(4'b0010));
    @(posedge clk); #1;
    req_valid = 4'b0001;
    req_a[0 +: WIDTH] = 8'h07;
    req_b[0 +: WIDTH] = 8'h07;
    req_op[0 +: OPW]  = OPW'(0);
    n = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 6; k++) begin
      chk("bp_valid",  32'(rsp_valid),  32'(1));
      chk("bp_id",     32'(rsp_id),     32'(1));
      chk("bp_result", 32'(rsp_result), 32'(1));
      chk("bp_ready",  32'(req_ready),  32'(0));
      if (k < 5) @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_no_grant", 32'(req_ready), 32'(0));
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'(4'b0001));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Async reset while a request is in EXEC
    do_one(2, 8'h44, 8'h44, OPW'(0), r, e, id, lat);
    chk("pre_rst_id", 32'(id), 32'(2));
    chk("pre_rst_res", 32'(r), 32'(1));
    req_valid = 4'b0010;
    req_a[1*WIDTH +: WIDTH] = 8'h01;
    req_b[1*WIDTH +: WIDTH] = 8'h01;
    req_op[1*OPW +: OPW]    = OPW'(0);
    n = 0;
    @(negedge clk);
    while (req_ready === '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_exec_grant", 32'(req_ready), 32'(4'b0010));
    @(posedge clk); #1;
    req_valid = '0;
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",   32'(busy),       32'(0));
    chk("mid_rst_valid",  32'(rsp_valid),  32'(0));
    chk("mid_rst_id",     32'(rsp_id),     32'(0));
    chk("mid_rst_result", 32'(rsp_result), 32'(0));
    chk("mid_rst_err",    32'(rsp_err),    32'(0));
    @(negedge clk);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_no_valid", 32'(rsp_valid), 32'(0));
    end
    do_one(3, 8'h10, 8'h20, OPW'(5), r, e, id, lat);
    chk("post_rst_id",  32'(id), 32'(3));
    chk("post_rst_res", 32'(r),  32'(1));
    chk("post_rst_lat", 32'(lat), 32'(2));

    // Round-robin fairness with all requesters held valid (pointer is 0 now)
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) new_ops(i);
    req_valid = '1;
    got = 0;
    n = 0;
    while (got < 5 && n < 60) begin
      @(negedge clk);
      n++;
      if (req_ready !== '0) begin
        order[got] = onehot_idx(req_ready);
        got++;
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    chk("rr_count", 32'(got), 32'(5));
    for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
    repeat (4) @(posedge clk);
    #1;

    // Randomised traffic with backpressure
    run_random(2000);

    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
